// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer_pkg
// Brief    : State encodings, opcodes, trap causes and decode class type.
// Revision : 1.0
// ============================================================================
package multicycle_sequencer_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_ECALL   = 2'd3;

  typedef struct packed {
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_jump;
    logic is_legal;
    logic is_system;
  } inst_class_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer_if
// Brief    : Control/handshake bundle between sequencer and datapath/memory.
// Revision : 1.0
// ============================================================================
interface multicycle_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 run;
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 mem_ready;
  logic [2:0]           state;
  logic                 ir_write;
  logic                 pc_write;
  logic                 pc_src;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_addr_sel;
  logic                 reg_write;
  logic                 retire;
  logic [CNT_WIDTH-1:0] instret;
  logic                 trap;
  logic [1:0]           trap_cause;

  modport master (
    input  run, opcode, branch_taken, mem_ready,
    output state, ir_write, pc_write, pc_src, mem_read, mem_write,
           mem_addr_sel, reg_write, retire, instret, trap, trap_cause
  );

  modport slave (
    output run, opcode, branch_taken, mem_ready,
    input  state, ir_write, pc_write, pc_src, mem_read, mem_write,
           mem_addr_sel, reg_write, retire, instret, trap, trap_cause
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer_inst_class_decode.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer_inst_class_decode
// Brief    : Combinational opcode classifier for the sequencer.
// Revision : 1.0
// ============================================================================
module multicycle_sequencer_inst_class_decode
  import multicycle_sequencer_pkg::*;
(
  input  logic [6:0]  opcode,
  output inst_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC: cls.is_legal = 1'b1;
      OP_LOAD: begin
        cls.is_legal = 1'b1;
        cls.is_load  = 1'b1;
      end
      OP_STORE: begin
        cls.is_legal = 1'b1;
        cls.is_store = 1'b1;
      end
      OP_BRANCH: begin
        cls.is_legal  = 1'b1;
        cls.is_branch = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        cls.is_legal = 1'b1;
        cls.is_jump  = 1'b1;
      end
      OP_SYSTEM: cls.is_system = 1'b1;
      default:   cls = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Brief    : Multi-cycle CPU control FSM with memory wait timeout and instret.
// Revision : 1.0
// ============================================================================
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 trap_q, trap_d;
  logic [1:0]           cause_q, cause_d;
  inst_class_t          cls;
  logic [2:0]           next_inst;
  logic                 timeout;
  logic                 retire;

  multicycle_sequencer_inst_class_decode u_decode (
    .opcode (bus.opcode),
    .cls    (cls)
  );

  assign next_inst = bus.run ? S_FETCH : S_IDLE;
  // The wait that reaches the limit traps only if memory is still not ready.
  assign timeout   = !bus.mem_ready && (wait_q == WAIT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    trap_d    = trap_q;
    cause_d   = cause_q;
    instret_d = instret_q + CNT_WIDTH'(retire);
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (cls.is_system) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ECALL;
        end else if (!cls.is_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.is_branch)                   state_d = next_inst;
        else if (cls.is_load || cls.is_store) state_d = S_MEM;
        else                                  state_d = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = cls.is_load ? S_WB : next_inst;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB:    state_d = next_inst;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_TRAP) trap_d = 1'b1;
  end

  always_comb begin
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.reg_write    = 1'b0;
    retire           = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.ir_write = bus.mem_ready;
      end
      S_EXEC: begin
        if (cls.is_branch) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = bus.branch_taken;
          retire       = 1'b1;
        end
      end
      S_MEM: begin
        bus.mem_addr_sel = 1'b1;
        if (cls.is_load) begin
          bus.mem_read = 1'b1;
        end else begin
          bus.mem_write = 1'b1;
          if (bus.mem_ready) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
          end
        end
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        bus.pc_src    = cls.is_jump;
        retire        = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.retire     = retire;
  assign bus.state      = state_q;
  assign bus.instret    = instret_q;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Brief    : Scoreboard bench for the multi-cycle sequencer (4-bit instret).
// Revision : 1.0
// ============================================================================
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_WIDTH(CW)) bus ();

  multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit is_trap;
    int st;
    int pc_src;
    int reg_write;
    int mem_write;
    int cause;
    int lat;
    int cnt;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            fetch_wait = 0;
  int            mem_wait   = 0;
  logic [CW-1:0] model_cnt  = '0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Memory responder: raises mem_ready after a programmed number of wait cycles.
  initial begin : mem_model
    logic [2:0] prev;
    int         waited;
    prev = S_IDLE;
    waited = 0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.state != prev) waited = 0;
      else waited++;
      prev = bus.state;
      if (bus.state == S_FETCH)    bus.mem_ready = (waited >= fetch_wait);
      else if (bus.state == S_MEM) bus.mem_ready = (waited >= mem_wait);
      else                         bus.mem_ready = 1'b0;
    end
  end

  int   cyc = 0;
  logic trap_prev = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      cyc = 0;
    end else begin
      if (bus.state >= S_FETCH && bus.state <= S_WB) cyc++;
      case (bus.state)
        S_FETCH: begin
          check("fetch_mem_read", int'(bus.mem_read), 1);
          check("fetch_addr_sel", int'(bus.mem_addr_sel), 0);
          check("fetch_ir_write", int'(bus.ir_write), int'(bus.mem_ready));
        end
        S_MEM:  check("mem_addr_sel", int'(bus.mem_addr_sel), 1);
        S_IDLE, S_TRAP:
          check("quiet_strobes", int'({bus.ir_write, bus.pc_write, bus.mem_read,
                                       bus.mem_write, bus.reg_write, bus.retire}), 0);
        default: ;
      endcase
      if (bus.retire) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got retire in state %0d expected none", bus.state);
        end else begin
          e = exp_q.pop_front();
          check("retire_state", int'(bus.state), e.st);
          check("retire_pc_write", int'(bus.pc_write), 1);
          check("retire_pc_src", int'(bus.pc_src), e.pc_src);
          check("retire_reg_write", int'(bus.reg_write), e.reg_write);
          check("retire_mem_write", int'(bus.mem_write), e.mem_write);
          check("retire_instret", int'(bus.instret), e.cnt);
          check("retire_latency", cyc, e.lat);
        end
        cyc = 0;
      end
      if (bus.trap && !trap_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_trap: got cause %0d expected no trap", bus.trap_cause);
        end else begin
          e = exp_q.pop_front();
          check("trap_state", int'(bus.state), e.st);
          check("trap_cause", int'(bus.trap_cause), e.cause);
          check("trap_latency", cyc, e.lat);
        end
        cyc = 0;
      end
    end
    trap_prev = bus.trap;
  end

  task automatic wait_for(input bit want_trap, input int budget, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = want_trap ? (bus.state == S_TRAP) : bus.retire;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_bound: no event after %0d cycles, required within %0d", name, n, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input string name, input logic [6:0] op, input logic br,
                       input int fw, input int mw, input int st, input int src,
                       input int rw, input int mwr, input int lat, input bit drop_run);
    exp_t e;
    int   n;
    bus.opcode       = op;
    bus.branch_taken = br;
    fetch_wait       = fw;
    mem_wait         = mw;
    e = '{is_trap: 1'b0, st: st, pc_src: src, reg_write: rw, mem_write: mwr,
          cause: 0, lat: lat, cnt: int'(model_cnt)};
    model_cnt++;
    exp_q.push_back(e);
    if (drop_run) begin
      n = 0;
      while (bus.state != S_MEM && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      bus.run = 1'b0;
    end
    wait_for(1'b0, 60, name);
  endtask

  task automatic issue_trap(input string name, input logic [6:0] op, input int fw,
                            input int cause, input int lat);
    exp_t e;
    bus.opcode = op;
    fetch_wait = fw;
    e = '{is_trap: 1'b1, st: int'(S_TRAP), pc_src: 0, reg_write: 0, mem_write: 0,
          cause: cause, lat: lat, cnt: 0};
    exp_q.push_back(e);
    wait_for(1'b1, 60, name);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    bus.run   = 1'b0;
    model_cnt = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst              = 1'b1;
    bus.run          = 1'b0;
    bus.opcode       = OP_RTYPE;
    bus.branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_state", int'(bus.state), int'(S_IDLE));
    check("rst_mem_read", int'(bus.mem_read), 0);
    check("rst_instret", int'(bus.instret), 0);
    check("rst_trap", int'(bus.trap), 0);
    check("rst_trap_cause", int'(bus.trap_cause), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_without_run", int'(bus.state), int'(S_IDLE));
    bus.run = 1'b1;

    //     name                opcode     br    fw  mw  state   src rw mw lat
    issue("rtype",            OP_RTYPE,  1'b0, 0,  0,  S_WB,   0, 1, 0, 4,  1'b0);
    issue("load_wait3",       OP_LOAD,   1'b0, 0,  3,  S_WB,   0, 1, 0, 8,  1'b0);
    issue("branch_taken",     OP_BRANCH, 1'b1, 0,  0,  S_EXEC, 1, 0, 0, 3,  1'b0);
    issue("branch_not_taken", OP_BRANCH, 1'b0, 0,  0,  S_EXEC, 0, 0, 0, 3,  1'b0);
    issue("store",            OP_STORE,  1'b0, 0,  0,  S_MEM,  0, 0, 1, 4,  1'b0);
    issue("jal",              OP_JAL,    1'b0, 0,  0,  S_WB,   1, 1, 0, 4,  1'b0);
    issue("jalr_fw2",         OP_JALR,   1'b0, 2,  0,  S_WB,   1, 1, 0, 6,  1'b0);
    issue("lui",              OP_LUI,    1'b0, 0,  0,  S_WB,   0, 1, 0, 4,  1'b0);
    issue("auipc_fw1",        OP_AUIPC,  1'b0, 1,  0,  S_WB,   0, 1, 0, 5,  1'b0);
    issue("itype",            OP_ITYPE,  1'b0, 0,  0,  S_WB,   0, 1, 0, 4,  1'b0);
    issue("store_fw15",       OP_STORE,  1'b0, 15, 0,  S_MEM,  0, 0, 1, 19, 1'b0);
    issue("load_mw15",        OP_LOAD,   1'b0, 0,  15, S_WB,   0, 1, 0, 20, 1'b0);
    for (int i = 0; i < 5; i++)
      issue("rtype_wrap",     OP_RTYPE,  1'b0, 0,  0,  S_WB,   0, 1, 0, 4,  1'b0);
    check("instret_wrapped", int'(bus.instret), int'(model_cnt));

    issue("store_b2b",        OP_STORE,  1'b0, 0,  0,  S_MEM,  0, 0, 1, 4,  1'b0);
    issue("store_run_drop",   OP_STORE,  1'b0, 0,  3,  S_MEM,  0, 0, 1, 7,  1'b1);
    check("park_idle", int'(bus.state), int'(S_IDLE));
    repeat (3) @(posedge clk);
    #1;
    check("park_idle_hold", int'(bus.state), int'(S_IDLE));
    check("park_instret", int'(bus.instret), int'(model_cnt));

    // Reset asserted while a store is waiting in MEM.
    bus.opcode = OP_STORE;
    fetch_wait = 0;
    mem_wait   = 10;
    bus.run    = 1'b1;
    n = 0;
    while (bus.state != S_MEM && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("pre_rst_mem_write", int'(bus.mem_write), 1);
    rst = 1'b1;
    #2;
    check("async_rst_state", int'(bus.state), int'(S_IDLE));
    check("async_rst_mem_write", int'(bus.mem_write), 0);
    check("async_rst_instret", int'(bus.instret), 0);
    model_cnt = '0;
    @(posedge clk); #1;
    rst     = 1'b0;
    bus.run = 1'b1;

    issue_trap("illegal", 7'b1111111, 0, int'(CAUSE_ILLEGAL), 2);
    repeat (20) @(posedge clk);
    #1;
    check("trap_stuck_state", int'(bus.state), int'(S_TRAP));
    check("trap_flag", int'(bus.trap), 1);
    check("trap_cause_hold", int'(bus.trap_cause), int'(CAUSE_ILLEGAL));

    do_reset();
    bus.run = 1'b1;
    issue_trap("fetch_timeout", OP_RTYPE, 100, int'(CAUSE_TIMEOUT), 16);

    do_reset();
    bus.run = 1'b1;
    issue_trap("ecall", OP_SYSTEM, 0, int'(CAUSE_ECALL), 2);
    check("ecall_trap_flag", int'(bus.trap), 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the CPU datapath (PC, register file, ALU, unified memory) over several clocks per instruction.
- Replaces the single-cycle flow. It issues per-state enables and mux selects and handshakes with a memory that may stall.
- Sits beside the Controller: the Controller still supplies ALU/immediate decode; this block owns *when* each datapath register updates.
- Counts retired instructions and traps on illegal opcodes, memory timeout or ECALL.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before trapping (≥1)
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; 1 = keep issuing instructions, 0 = stop at next instruction boundary
opcode  in  7  inst[6:0] from the instruction register (valid from DECODE onward)
branch_taken  in  1  ALU compare result, sampled in EXEC
mem_ready  in  1  memory completes the current read/write this cycle
state  out  3  current FSM state encoding
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = ALU target
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_addr_sel  out  1  0 = PC (fetch), 1 = ALUResult (data)
reg_write  out  1  register file write enable
retire  out  1  one-cycle pulse when an instruction completes
instret  out  CNT_WIDTH  retired-instruction count
trap  out  1  sticky trap flag
trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout, 3 ECALL/halt

Behaviour:
- Reset (async, immediate): state=IDLE; all strobes 0; instret=0; trap=0; trap_cause=0; wait counter=0. Asserting rst mid-request drops mem_read/mem_write in the same cycle.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Strobes are combinational from state plus inputs (Mealy on mem_ready and branch_taken). instret and trap fields are registered.
- "next" means FETCH if run=1, else IDLE. run is sampled only at instruction boundaries.
- IDLE: no strobes. Go to FETCH when run=1.
- FETCH: mem_read=1, mem_addr_sel=0. On mem_ready: ir_write=1, go to DECODE.
- DECODE: classify opcode.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. These go to EXEC.
  - 1110011 goes to TRAP with cause 3.
  - Anything else goes to TRAP with cause 1.
- EXEC: always one cycle.
  - BRANCH: pc_write=1, pc_src=branch_taken, retire=1, go to next.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: mem_addr_sel=1.
  - LOAD: mem_read=1. On mem_ready go to WB.
  - STORE: mem_write=1. On mem_ready: pc_write=1, pc_src=0, retire=1, go to next.
- WB (one cycle): reg_write=1, pc_write=1, retire=1, go to next. pc_src=1 for JAL/JALR, else 0.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP with cause 2.
  - mem_ready in the same cycle as the limit wins: no trap.
- TRAP: all strobes 0; trap=1. Leaves only on rst. run and mem_ready are ignored. trap_cause latches on entry.
- instret increments on every retire and wraps from all-ones to 0.
- Minimum latency (mem_ready tied 1):
  - Branch: 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Decomposition:
- variables.v (shared `define file) gains:
  - state encodings (`S_IDLE … `S_TRAP)
  - opcode constants (`OP_RTYPE, `OP_ITYPE, `OP_LOAD, `OP_STORE, `OP_BRANCH, `OP_JAL, `OP_JALR, `OP_LUI, `OP_AUIPC, `OP_SYSTEM)
  - trap cause codes
- One sub-module, inst_class_decode: combinational opcode → {is_branch, is_load, is_store, is_jump, is_legal, is_system}.
- FSM, wait counter and instret stay in multicycle_sequencer.

Test Plan:
- R-type (opcode 0110011), run=1, mem_ready=1 → states 1,2,3,5. ir_write in cycle 1. reg_write and pc_write with pc_src=0 in cycle 4. instret 0→1.
- Load 0000011, FETCH ready immediately, MEM mem_ready after 3 wait cycles → mem_read with mem_addr_sel=1 held 4 cycles, then WB. Total 8 cycles; retire pulses once.
- Branch 1100011 with branch_taken=1 → EXEC asserts pc_write=1, pc_src=1, retire=1, returns to FETCH. With branch_taken=0 → pc_src=0.
- Opcode 1111111 → DECODE goes to TRAP; trap=1, trap_cause=1. Strobes stay 0 across 20 more cycles despite run=1.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=16 → TRAP after 16 wait cycles with cause 2. Repeat with mem_ready=1 on cycle 16 → no trap.
- Two back-to-back store runs:
  - run dropped mid-instruction → store completes and the FSM parks in IDLE.
  - rst pulsed during MEM → state=0, mem_write=0 immediately, instret=0.
  - instret preset to all-ones via a long run → wraps to 0.
